pe_result_sink: RTL and testbench
=================================

# pe_result_sink

Receive-side counterpart of the PE operand sequencer: collects the `result`/`vld_o` stream that `parallel_pe` emits at the end of each instruction. Results go into a small FIFO and drain in order to a result-memory write port with valid/ready backpressure, at consecutive addresses from a programmable base. Per-job result counting, completion and overflow status replace the bench-side golden compare path with a hardware writeback path.

## Interface
Parameters:
- `DATA_W`, 32, PE result width.
- `ADDR_W`, 8, result-memory address width.
- `FIFO_DEPTH`, 4, buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle job start; honoured only in IDLE or DONE.
- `base_addr`  in  ADDR_W  first write address, sampled on accepted `start`.
- `expected`  in  ADDR_W+1  number of results in the job, sampled on accepted `start`.
- `pe_vld_o`  in  1  PE result valid, one-cycle pulse per result.
- `pe_result`  in  DATA_W  PE result, qualified by `pe_vld_o`.
- `wr_en`  out  1  memory write valid.
- `wr_addr`  out  ADDR_W  memory write address.
- `wr_data`  out  DATA_W  memory write data.
- `wr_ready`  in  1  memory accepts the write this cycle.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  high in DONE (level).
- `overflow`  out  1  sticky error: a result was dropped or was unexpected.
- `res_cnt`  out  ADDR_W+1  results accepted in the current job.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + `start`: go to RUN. Load the address counter with `base_addr`, latch `expected`, clear `res_cnt` and `overflow`.
  - RUN, `res_cnt == expected`: go to DRAIN. This covers `expected == 0`: RUN is held one cycle, then DRAIN.
  - DRAIN, FIFO empty: go to DONE.
  - `start` in RUN/DRAIN: ignored.
- Push:
  - In RUN, `pe_vld_o` writes `pe_result` into the FIFO and increments `res_cnt`.
  - A push is accepted if occupancy < `FIFO_DEPTH`, or if occupancy is full and a pop occurs the same cycle.
  - Otherwise the result is dropped, `overflow` is set, and `res_cnt` still increments, so the job terminates.
- `pe_vld_o` in DRAIN or DONE sets `overflow`; nothing is stored.
- `pe_vld_o` in IDLE is ignored.
- Pop:
  - `wr_en` = FIFO not empty.
  - `wr_data` = FIFO head; `wr_addr` = address counter.
  - A transfer occurs when `wr_en && wr_ready`. On transfer the head is popped and the address increments modulo 2^ADDR_W (0xFF → 0x00).
- While `wr_en` is high and `wr_ready` is low, `wr_addr`/`wr_data` hold stable.
- FIFO drains in every state, including after the job reaches DONE. Order is strictly preserved.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `overflow`=0, `res_cnt`=0. FSM in IDLE, FIFO empty.
- `start` at edge N: `busy`=1 from cycle N+1.
- `pe_vld_o` at edge N (FIFO empty, RUN): `wr_en`=1 with that data in cycle N+1. Minimum latency is 1 cycle.
- With `wr_ready` held high, throughput is one result per cycle. Back-to-back `pe_vld_o` never overflows.
- The last result is accepted at edge N; RUN→DRAIN at edge N+1 (`res_cnt==expected` seen).
- The final pop completes at edge M; `done`=1 and `busy`=0 from cycle max(N+2, M+1).
- `overflow` rises the cycle after the offending `pe_vld_o` and holds until the next accepted `start` or reset.
- Asynchronous reset mid-job: immediately return to IDLE, flush the FIFO, drop `wr_en`. Buffered results are lost and no partial write completes.

## Test plan
- **Nominal.** Inputs: `base_addr`=0x10, `expected`=4, four `pe_vld_o` pulses of 0x11,0x22,0x33,0x44 with gaps; `wr_ready`=1.
  - Writes (0x10,0x11), (0x11,0x22), (0x12,0x33), (0x13,0x44).
  - `done`=1 two cycles after the last pulse; `overflow`=0.
- **Backpressure.** `wr_ready`=0 for 20 cycles; `expected`=4, four back-to-back pulses.
  - FIFO fills, no drop, `wr_en` held on the first entry.
  - On release, four in-order writes, then DONE.
- **Overflow.** `FIFO_DEPTH`=4, `wr_ready`=0, `expected`=6, six pulses.
  - 5th and 6th results dropped, `overflow`=1, `res_cnt`=6.
  - Four writes after `wr_ready` rises, then DONE.
- **Full + simultaneous pop.** FIFO full and `wr_ready`=1 in the same cycle as `pe_vld_o`.
  - Push accepted, no overflow, occupancy stays 4.
- **Wrap and zero.** `base_addr`=0xFE, `expected`=3 → addresses 0xFE, 0xFF, 0x00.
  - `expected`=0 → DONE two cycles after `start`, no writes.
- **Stray pulse and reset.**
  - `pe_vld_o` in DONE → `overflow`=1.
  - `rst_n` low mid-RUN with 2 entries buffered → `wr_en`=0 immediately. After reset, a new `start` runs cleanly with no stale data.

Source files
------------

// File: rtl/pe_result_sink.sv
// pe_result_sink: buffers PE results in a small FIFO and writes them to result memory
// at consecutive addresses, tracking per-job result count, completion and overflow.
module pe_result_sink #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   expected,
  input  logic              pe_vld_o,
  input  logic [DATA_W-1:0] pe_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   res_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] exp_q, exp_d, cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [PW-1:0] rd_q, rd_d, wp_q, wp_d;
  logic [PW:0] occ_q, occ_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic go, pop, push, vld_run, stray;
  always_comb begin
    go      = start && (state_q == IDLE || state_q == DONE);
    pop     = wr_en && wr_ready;
    // once the job has its full count, further pulses are unexpected rather than stored
    vld_run = pe_vld_o && state_q == RUN && cnt_q != exp_q;
    push    = vld_run && (!occ_q[PW] || pop);
    stray   = pe_vld_o && state_q != IDLE && !vld_run;
    state_d = go ? RUN :
              (state_q == RUN && cnt_q == exp_q) ? DRAIN :
              (state_q == DRAIN && !wr_en) ? DONE : state_q;
    addr_d  = go ? base_addr : addr_q + ADDR_W'(pop);
    exp_d   = go ? expected : exp_q;
    cnt_d   = go ? '0 : cnt_q + (ADDR_W+1)'(vld_run);
    ovf_d   = go ? 1'b0 : ovf_q | stray | (vld_run && !push);
    rd_d    = rd_q + PW'(pop);
    wp_d    = wp_q + PW'(push);
    occ_d   = occ_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      wp_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      wp_q    <= wp_d;
      occ_q   <= occ_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= pe_result;
  assign wr_en    = occ_q != '0;
  assign wr_addr  = addr_q;
  assign wr_data  = wr_en ? mem_q[rd_q] : '0;
  assign busy     = state_q == RUN || state_q == DRAIN;
  assign done     = state_q == DONE;
  assign overflow = ovf_q;
  assign res_cnt  = cnt_q;
endmodule

// File: tb/tb_pe_result_sink.sv
// tb_pe_result_sink: randomized and directed jobs; a queue of expected memory writes
// is filled by the driver and drained by an independent write-port monitor.
module tb_pe_result_sink;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, start = 0, pe_vld_o = 0, wr_ready = 0;
  logic [7:0] base_addr = 0;
  logic [8:0] expected = 0;
  logic [31:0] pe_result = 0;
  logic wr_en, busy, done, overflow;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  logic [8:0] res_cnt;
  int tests = 0, fails = 0;
  int rdy_pct = 100;
  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  logic [7:0] m_addr;
  int m_exp, m_cnt;
  logic m_ovf, m_started;

  pe_result_sink #(.DATA_W(32), .ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .expected(expected),
    .pe_vld_o(pe_vld_o), .pe_result(pe_result), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done),
    .overflow(overflow), .res_cnt(res_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && wr_en) begin
      if (q.size() == 0) chk("spurious_wr_en", wr_en, 0);
      else begin
        chk("wr_addr", wr_addr, q[0].a);
        chk("wr_data", wr_data, q[0].d);
        if (wr_ready) void'(q.pop_front());
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
    start = 0;
    pe_vld_o = 0;
    wr_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic job_start(input logic [7:0] b, input int n);
    step();
    start = 1;
    base_addr = b;
    expected = 9'(n);
    m_addr = b;
    m_exp = n;
    m_cnt = 0;
    m_ovf = 0;
    m_started = 1;
  endtask

  // Occupancy equals the outstanding queue length; a full FIFO only accepts if it pops now.
  task automatic pulse(input logic [31:0] d);
    step();
    pe_vld_o = 1;
    pe_result = d;
    if (!m_started) return;
    if (m_cnt < m_exp) begin
      m_cnt++;
      if (q.size() < DEPTH || wr_ready) begin
        q.push_back('{m_addr, d});
        m_addr++;
      end else m_ovf = 1;
    end else m_ovf = 1;
  endtask

  task automatic finish_job(input string n);
    int k = 0;
    while (!done && k < 500) begin step(); k++; end
    chk({n, "_done"}, done, 1);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_overflow"}, overflow, m_ovf);
    chk({n, "_res_cnt"}, res_cnt, m_cnt);
    k = 0;
    while (q.size() != 0 && k < 200) begin step(); k++; end
    step();
    chk({n, "_queue_left"}, q.size(), 0);
    chk({n, "_wr_en_idle"}, wr_en, 0);
  endtask

  initial begin
    #3;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_res_cnt", res_cnt, 0);
    m_started = 0;
    step();
    rst_n = 1;
    pulse(32'hdead);
    step();
    chk("idle_pulse_ignored", overflow, 0);

    rdy_pct = 100;
    job_start(8'h10, 4);
    step();
    chk("busy_after_start", busy, 1);
    pulse(32'h11); step();
    pulse(32'h22); step(); step();
    pulse(32'h33); step();
    pulse(32'h44);
    step(); step();
    chk("nominal_done_early", done, 0);
    step();
    chk("nominal_done_time", done, 1);
    finish_job("nominal");

    rdy_pct = 0;
    job_start(8'h20, 4);
    for (int i = 0; i < 4; i++) pulse(32'h100 + i);
    repeat (20) step();
    chk("bp_wr_en_held", wr_en, 1);
    chk("bp_overflow", overflow, 0);
    rdy_pct = 100;
    finish_job("backpressure");

    rdy_pct = 0;
    job_start(8'h30, 6);
    for (int i = 0; i < 6; i++) pulse(32'h200 + i);
    step();
    chk("ovf_flag", overflow, 1);
    chk("ovf_res_cnt", res_cnt, 6);
    rdy_pct = 100;
    finish_job("overflow");

    rdy_pct = 0;
    job_start(8'h40, 5);
    for (int i = 0; i < 4; i++) pulse(32'h300 + i);
    step();
    rdy_pct = 100;
    pulse(32'h304);
    step();
    chk("full_pop_no_ovf", overflow, 0);
    finish_job("full_pop");

    job_start(8'hFE, 3);
    for (int i = 0; i < 3; i++) pulse(32'h400 + i);
    finish_job("wrap");

    job_start(8'h55, 0);
    step(); step();
    chk("zero_done_early", done, 0);
    step();
    chk("zero_done_time", done, 1);
    chk("zero_no_write", wr_en, 0);
    finish_job("zero");

    pulse(32'hbad);
    step();
    chk("stray_overflow", overflow, 1);

    rdy_pct = 0;
    job_start(8'h60, 4);
    pulse(32'h501); pulse(32'h502);
    step();
    #2 rst_n = 0;
    #1;
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_busy", busy, 0);
    q.delete();
    m_started = 0;
    step(); step();
    rst_n = 1;
    chk("post_rst_res_cnt", res_cnt, 0);
    chk("post_rst_wr_addr", wr_addr, 0);
    rdy_pct = 100;
    job_start(8'h70, 2);
    pulse(32'h601); pulse(32'h602);
    finish_job("post_reset");

    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(8);
      rdy_pct = $urandom_range(100, 30);
      job_start(8'($urandom), n);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(2)) step();
        pulse($urandom);
      end
      rdy_pct = 100;
      finish_job("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
